// File: rtl/ram_1r1w.sv
// rtl/ram_1r1w.sv - simple dual-port RAM, one registered read port and one write port
// Optional debug trace: define RAM_DEBUG_DISPLAY_EN to print each read/write with the TAG prefix.
module ram_1r1w #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4,
    parameter     TAG        = "ram"
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [WIDTH-1:0]      dataIn,
    output logic [WIDTH-1:0]      dataOut
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Contents are deliberately not reset; callers sweep-write them after reset.
    logic [WIDTH-1:0] mem [DEPTH];

    // Same-address read and write on one edge returns the incoming data (write-first).
    logic             collide;
    logic [WIDTH-1:0] read_word;

    // Select the word the read port captures this edge.
    always_comb begin
        collide   = we && (readAddr == writeAddr);
        read_word = collide ? dataIn : mem[readAddr];
    end

    // Array write; strobes are ignored while reset is held.
    always_ff @(posedge clk) begin
        if (res && we) begin
            mem[writeAddr] <= dataIn;
        end
    end

    // Output register: cleared asynchronously, loaded only on a read, otherwise held.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dataOut <= '0;
        end else if (re) begin
            dataOut <= read_word;
        end
    end

`ifdef RAM_DEBUG_DISPLAY_EN
    // Trace accepted operations for debug runs.
    always_ff @(posedge clk) begin
        if (res) begin
            if (we) begin
                $display("[%s] write 0x%0h <= 0x%0h", TAG, writeAddr, dataIn);
            end
            if (re) begin
                $display("[%s] read 0x%0h", TAG, readAddr);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_ram_1r1w.sv
// tb/tb_ram_1r1w.sv - self-checking bench for ram_1r1w
module tb_ram_1r1w;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int N  = 2 ** AW;

    logic          clk;
    logic          res;
    logic          re;
    logic          we;
    logic [AW-1:0] readAddr;
    logic [AW-1:0] writeAddr;
    logic [W-1:0]  dataIn;
    logic [W-1:0]  dataOut;

    int checks = 0;
    int errors = 0;

    // Reference model: memory as a plain array with written flags, output as a value.
    logic [W-1:0] mem_m [N];
    bit           valid_m [N];
    logic [W-1:0] exp_out;
    bit           exp_known;

    ram_1r1w #(.WIDTH(W), .ADDR_WIDTH(AW), .TAG("tbram")) dut (
        .clk       (clk),
        .res       (res),
        .re        (re),
        .we        (we),
        .readAddr  (readAddr),
        .writeAddr (writeAddr),
        .dataIn    (dataIn),
        .dataOut   (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of stimulus, advance past the edge, update the model, check output.
    task automatic step(input string tag, input logic r, input logic w,
                        input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                        input logic [W-1:0] d);
        re = r; we = w; readAddr = ra; writeAddr = wa; dataIn = d;
        @(posedge clk);
        #1;
        if (res) begin
            if (r) begin
                if (w && ra == wa) begin
                    exp_out   = d;
                    exp_known = 1'b1;
                end else begin
                    exp_out   = mem_m[ra];
                    exp_known = valid_m[ra];
                end
            end
            if (w) begin
                mem_m[wa]   = d;
                valid_m[wa] = 1'b1;
            end
        end
        if (exp_known) chk(tag, dataOut, exp_out);
        re = 1'b0; we = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        res = 1'b0;
        #1;
        exp_out   = '0;
        exp_known = 1'b1;
        chk(tag, dataOut, '0);
        res = 1'b1;
    endtask

    initial begin
        res = 1'b0; re = 1'b0; we = 1'b0;
        readAddr = '0; writeAddr = '0; dataIn = '0;
        for (int i = 0; i < N; i++) valid_m[i] = 1'b0;
        exp_out = '0; exp_known = 1'b1;

        #1;
        chk("reset_out", dataOut, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        res = 1'b1;

        // Reset behaviour: load DEADBEEF into the output, then reset asynchronously.
        step("load_dead_w", 1'b0, 1'b1, 4'd0, 4'd0, 32'hDEADBEEF);
        step("load_dead_r", 1'b1, 1'b0, 4'd0, 4'd0, 32'h0);
        chk("dead_out", dataOut, 32'hDEADBEEF);
        res = 1'b0;
        #1;
        exp_out = '0; exp_known = 1'b1;
        chk("async_clear", dataOut, '0);
        step("ignored_in_reset", 1'b1, 1'b1, 4'd0, 4'd0, 32'h11111111);
        chk("held_in_reset", dataOut, '0);
        #1;
        res = 1'b1;
        step("idle_after_rst", 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
        chk("zero_after_rst", dataOut, '0);
        step("retained", 1'b1, 1'b0, 4'd0, 4'd0, 32'h0);
        chk("retained_val", dataOut, 32'hDEADBEEF);

        // Write then read.
        step("wr3", 1'b0, 1'b1, 4'd0, 4'd3, 32'h12345678);
        step("rd3", 1'b1, 1'b0, 4'd3, 4'd0, 32'h0);
        chk("rd3_val", dataOut, 32'h12345678);

        // Hold: write the read address with re low; output must not change.
        step("hold_w3", 1'b0, 1'b1, 4'd3, 4'd3, 32'hAAAA5555);
        chk("hold_val", dataOut, 32'h12345678);
        step("rd3_new", 1'b1, 1'b0, 4'd3, 4'd0, 32'h0);
        chk("rd3_new_val", dataOut, 32'hAAAA5555);

        // Same-address collision is write-first.
        step("w5_1", 1'b0, 1'b1, 4'd0, 4'd5, 32'h1);
        step("collide5", 1'b1, 1'b1, 4'd5, 4'd5, 32'h2);
        chk("collide_val", dataOut, 32'h2);
        step("rd5", 1'b1, 1'b0, 4'd5, 4'd0, 32'h0);
        chk("mem5_val", dataOut, 32'h2);

        // Different-address concurrency.
        step("w7_r3", 1'b1, 1'b1, 4'd3, 4'd7, 32'hCAFE0000);
        chk("conc_r3", dataOut, 32'hAAAA5555);
        step("rd7", 1'b1, 1'b0, 4'd7, 4'd0, 32'h0);
        chk("conc_r7", dataOut, 32'hCAFE0000);

        // Full sweep, back-to-back reads.
        for (int i = 0; i < N; i++)
            step("sweep_w", 1'b0, 1'b1, 4'd0, AW'(i), 32'h01010101 * i);
        for (int i = 0; i < N; i++) begin
            step("sweep_r", 1'b1, 1'b0, AW'(i), 4'd0, 32'h0);
            chk($sformatf("sweep_%0d", i), dataOut, 32'h01010101 * i);
        end

        // Randomized traffic against the model, with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset("rand_reset");
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
